// File: rtl/baud_rate_generator.sv
// baud_rate_generator: phase-accumulator UART oversample/bit strobe generator; define BAUDGEN_CUSTOM_INC_EN for a runtime-programmable increment
module baud_rate_generator #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int OVERSAMPLE = 16,
    parameter int ACC_W      = 24
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [2:0]                    baud_select,
    input  logic                          custom_sel,
    input  logic [ACC_W-1:0]              custom_inc,
    output logic                          sample_ENABLE,
    output logic                          bit_ENABLE,
    output logic [$clog2(OVERSAMPLE)-1:0] sample_idx
);
    localparam int IDX_W = $clog2(OVERSAMPLE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OVERSAMPLE - 1);

    function automatic logic [63:0] table_inc(input int k);
        logic [63:0] baud;
        baud = k == 0 ? 64'd300 :
               k == 1 ? 64'd1200 :
               k == 2 ? 64'd4800 :
               k == 3 ? 64'd9600 :
               k == 4 ? 64'd19200 :
               k == 5 ? 64'd38400 :
               k == 6 ? 64'd57600 : 64'd115200;
        return (((baud * 64'(OVERSAMPLE)) << ACC_W) + 64'(CLK_FREQ / 2)) / 64'(CLK_FREQ);
    endfunction

    if (OVERSAMPLE < 2 || OVERSAMPLE > 64 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_bad_os
        $error("baud_rate_generator: OVERSAMPLE %0d must be a power of two in 2..64", OVERSAMPLE);
    end
    if (ACC_W < 16 || ACC_W > 32) begin : g_bad_acc
        $error("baud_rate_generator: ACC_W %0d must be in 16..32", ACC_W);
    end

    logic [ACC_W-1:0] inc_tab [8];
    for (genvar k = 0; k < 8; k++) begin : g_tab
        localparam logic [63:0] INC = table_inc(k);
        if (INC == 64'd0 || INC >= (64'd1 << ACC_W)) begin : g_bad_inc
            $error("baud_rate_generator: increment %0d for rate code %0d does not fit ACC_W", INC, k);
        end
        assign inc_tab[k] = INC[ACC_W-1:0];
    end

    logic [ACC_W-1:0] sel_inc;
`ifdef BAUDGEN_CUSTOM_INC_EN
    // custom increment overrides the table; zero would stall the NCO so it runs at the slowest rate instead
    always_comb sel_inc = custom_sel ? (custom_inc == '0 ? ACC_W'(1) : custom_inc) : inc_tab[baud_select];
`else
    logic unused_custom;
    assign unused_custom = ^{custom_sel, custom_inc};
    // table rate only; custom pins are kept for pin compatibility
    always_comb sel_inc = inc_tab[baud_select];
`endif

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] active_inc;
    logic [ACC_W:0]   acc_sum;
    logic             carry;
    logic             bit_tick;

    // accumulator carry is the sample tick; the last sample of a bit is a bit boundary
    always_comb begin
        acc_sum  = {1'b0, acc} + {1'b0, active_inc};
        carry    = acc_sum[ACC_W];
        bit_tick = carry && (sample_idx == LAST_IDX);
    end

    // idle/reset clears phase and tracks the selection; running only adopts a new rate at a bit boundary
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            acc           <= '0;
            active_inc    <= sel_inc;
            sample_idx    <= '0;
            sample_ENABLE <= 1'b0;
            bit_ENABLE    <= 1'b0;
        end else begin
            acc           <= acc_sum[ACC_W-1:0];
            sample_ENABLE <= carry;
            bit_ENABLE    <= bit_tick;
            if (carry) sample_idx <= sample_idx + IDX_W'(1);
            if (bit_tick) active_inc <= sel_inc;
        end
    end
endmodule
